scan_tester_engine: RTL and testbench

Parametrised successor to the serial tester command parser, sitting between the UART rx/tx pair and the DUT pin interface on the tester FPGA. It decodes a binary command stream and drives DUT clock, reset, scan-enable, test-mode, primary inputs and NCHAINS parallel scan chains. Scan load and unload run in one combined exchange pass. It adds programmable DUT clock division, packed multi-chain scan bytes, early abort and a receive timeout.

---
 rtl/scan_tester_engine.sv | 224 ++++++++++++++++++++++
 tb/tb_scan_tester_engine.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/scan_tester_engine.sv
// scan_tester_engine: binary command parser driving DUT clock, reset, primary I/O and parallel scan chains
module scan_tester_engine #(
  parameter int NPIS = 14,
  parameter int NPOS = 11,
  parameter int NCHAINS = 1,
  parameter int CLK_DIV = 1,
  parameter int RX_TIMEOUT = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               tx_ready,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               dut_clk,
  output logic               dut_rstn,
  output logic               dut_se,
  output logic               dut_tm,
  output logic [NPIS-1:0]    dut_pis,
  input  logic [NPOS-1:0]    dut_pos,
  output logic [NCHAINS-1:0] scan_in,
  input  logic [NCHAINS-1:0] scan_out,
  output logic               busy,
  output logic               err,
  output logic [15:0]        cycle_count
);
  localparam int NPB = (NPIS + 7) / 8;
  localparam int NOB = (NPOS + 7) / 8;
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int TW = $clog2(RX_TIMEOUT + 1) + 1;
  typedef enum logic [3:0] {
    IDLE, ARG_HI, ARG_LO, PI_LOAD, RST_PULSE, RUN,
    SH_RX, SH_CLK, SH_TX, PO_TX, TX_PULSE, TX_WAIT
  } state_t;
  state_t state, ret;
  logic [7:0] cmd, idx, rep;
  logic [15:0] rem, n_arg;
  logic [PW-1:0] pc, pc_nx;
  logic [3:0] rc;
  logic [TW-1:0] to;
  logic [NPB*8-1:0] pis_buf, pis_nx;
  logic [NOB*8-1:0] po_buf;
  logic [NPOS-1:0] pos_r;
  logic [NCHAINS-1:0] so_r;
  logic free, stop, lo, is_p, pc_end, rise, wait_st, to_hit;
  // pc walks one DUT clock period: CLK_DIV low cycles then CLK_DIV high cycles
  assign pc_end = pc == PW'(2 * CLK_DIV - 1);
  assign pc_nx = pc_end ? '0 : pc + 1'b1;
  assign rise = pc_nx == PW'(CLK_DIV);
  assign is_p = rx_valid && rx_data == "p";
  assign n_arg = {rem[15:8], rx_data};
  assign pis_nx = (NPB * 8)'({pis_buf, rx_data});
  assign wait_st = state inside {ARG_HI, ARG_LO, PI_LOAD, SH_RX};
  assign to_hit = to == TW'(RX_TIMEOUT);
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ret <= IDLE;
      cmd <= '0;
      idx <= '0;
      rep <= '0;
      rem <= '0;
      pc <= '0;
      rc <= '0;
      to <= '0;
      pis_buf <= '0;
      po_buf <= '0;
      pos_r <= '0;
      so_r <= '0;
      free <= 1'b0;
      stop <= 1'b0;
      lo <= 1'b0;
      tx_start <= 1'b0;
      tx_data <= '0;
      dut_clk <= 1'b0;
      dut_rstn <= 1'b0;
      dut_se <= 1'b0;
      dut_tm <= 1'b0;
      dut_pis <= '0;
      scan_in <= '0;
      busy <= 1'b0;
      err <= 1'b0;
      cycle_count <= '0;
    end else begin
      pos_r <= dut_pos;
      so_r <= scan_out;
      tx_start <= 1'b0;
      dut_rstn <= 1'b1;
      to <= '0;
      case (state)
        IDLE: if (rx_valid) begin
          busy <= 1'b1;
          cmd <= rx_data;
          idx <= '0;
          stop <= 1'b0;
          case (rx_data)
            "r": begin
              dut_rstn <= 1'b0;
              rc <= '0;
              cycle_count <= '0;
              err <= 1'b0;
              state <= RST_PULSE;
            end
            "e", "x": state <= ARG_HI;
            "f": begin
              dut_se <= 1'b0;
              dut_tm <= 1'b0;
              free <= 1'b1;
              pc <= '0;
              state <= RUN;
            end
            "i": state <= PI_LOAD;
            "o": begin
              po_buf <= (NOB * 8)'(pos_r);
              state <= PO_TX;
            end
            default: begin
              err <= 1'b1;
              tx_data <= "E";
              ret <= IDLE;
              state <= TX_PULSE;
            end
          endcase
        end
        ARG_HI: if (rx_valid) begin
          rem[15:8] <= rx_data;
          state <= ARG_LO;
        end
        ARG_LO: if (rx_valid) begin
          rem <= n_arg;
          free <= 1'b0;
          pc <= '0;
          dut_se <= cmd == "x";
          dut_tm <= cmd == "x";
          if (n_arg == 16'd0) begin
            tx_data <= "K";
            ret <= IDLE;
            state <= TX_PULSE;
          end else state <= cmd == "x" ? SH_RX : RUN;
        end
        PI_LOAD: if (rx_valid) begin
          pis_buf <= pis_nx;
          idx <= idx + 1'b1;
          if (idx == 8'(NPB - 1)) begin
            dut_pis <= pis_nx[NPIS-1:0];
            tx_data <= "K";
            ret <= IDLE;
            state <= TX_PULSE;
          end
        end
        RST_PULSE: begin
          rc <= rc + 1'b1;
          dut_rstn <= rc == 4'd15;
          if (rc == 4'd15) begin
            tx_data <= "K";
            ret <= IDLE;
            state <= TX_PULSE;
          end
        end
        RUN: begin
          pc <= pc_nx;
          dut_clk <= pc_nx >= PW'(CLK_DIV);
          if (rise) cycle_count <= cycle_count + 1'b1;
          if (is_p) stop <= 1'b1;
          if (pc_end) begin
            rem <= rem - 1'b1;
            if (stop || is_p || (!free && rem == 16'd1)) begin
              tx_data <= "K";
              ret <= IDLE;
              state <= TX_PULSE;
            end
          end
        end
        SH_RX: if (rx_valid) begin
          scan_in <= rx_data[NCHAINS-1:0];
          pc <= '0;
          state <= SH_CLK;
        end
        SH_CLK: begin
          pc <= pc_nx;
          dut_clk <= pc_nx >= PW'(CLK_DIV);
          if (rise) rep <= 8'(so_r);
          if (pc_end) state <= SH_TX;
        end
        SH_TX: begin
          tx_data <= rep;
          rem <= rem - 1'b1;
          ret <= rem == 16'd1 ? IDLE : SH_RX;
          state <= TX_PULSE;
        end
        PO_TX: begin
          tx_data <= po_buf[NOB*8-1 -: 8];
          po_buf <= po_buf << 8;
          idx <= idx + 1'b1;
          ret <= idx == 8'(NOB - 1) ? IDLE : PO_TX;
          state <= TX_PULSE;
        end
        TX_PULSE: if (tx_ready) begin
          tx_start <= 1'b1;
          lo <= 1'b0;
          state <= TX_WAIT;
        end
        TX_WAIT: begin
          if (!tx_ready) lo <= 1'b1;
          if (lo && tx_ready) begin
            state <= ret;
            busy <= ret != IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      // a silent host aborts any argument or exchange wait
      if (wait_st && !rx_valid) begin
        if (to_hit) begin
          err <= 1'b1;
          tx_data <= "T";
          ret <= IDLE;
          state <= TX_PULSE;
        end else to <= to + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_scan_tester_engine.sv
// tb_scan_tester_engine: directed vector table plus hand sequences for exchange, PO readback, free-run, timeout and reset
module tb_scan_tester_engine;
  localparam int CD = 2;
  logic clk = 1'b0, rst = 1'b1, rx_valid = 1'b0, tx_ready;
  logic [7:0] rx_data = '0, tx_data;
  logic tx_start, dut_clk, dut_rstn, dut_se, dut_tm, busy, err;
  logic [13:0] dut_pis;
  logic [10:0] dut_pos = '0;
  logic [1:0] scan_in, scan_out = '0;
  logic [15:0] cycle_count;
  logic [2:0] sr0 = '0, sr1 = '0;
  logic [7:0] txlog[$];
  int ri = 0, nchk = 0, nerr = 0;
  int mon_rise = 0, mon_high = 0, mon_rlow = 0;
  logic pclk = 1'b0;

  scan_tester_engine #(.NPIS(14), .NPOS(11), .NCHAINS(2), .CLK_DIV(CD), .RX_TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .tx_ready(tx_ready),
    .tx_start(tx_start), .tx_data(tx_data), .dut_clk(dut_clk), .dut_rstn(dut_rstn),
    .dut_se(dut_se), .dut_tm(dut_tm), .dut_pis(dut_pis), .dut_pos(dut_pos),
    .scan_in(scan_in), .scan_out(scan_out), .busy(busy), .err(err), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (tx_start) begin
        txlog.push_back(tx_data);
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // two 3-deep scan chains, each presenting its last stage on scan_out
  initial forever begin
    @(posedge dut_clk);
    sr0 = {sr0[1:0], scan_in[0]};
    sr1 = {sr1[1:0], scan_in[1]};
    scan_out = {sr1[2], sr0[2]};
  end

  initial forever begin
    @(negedge clk);
    if (dut_clk && !pclk) mon_rise++;
    if (dut_clk) mon_high++;
    if (!dut_rstn) mon_rlow++;
    pclk = dut_clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic check(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic expect_byte(input string nm, input logic [7:0] exp);
    int t = 0;
    while (txlog.size() <= ri && t < 3000) begin
      @(posedge clk);
      #2 t++;
    end
    if (txlog.size() <= ri) check(nm, 'h100, exp);
    else begin
      check(nm, txlog[ri], exp);
      ri++;
    end
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy && t < 5000) begin
      @(posedge clk);
      #2 t++;
    end
    check(nm, busy, 0);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_ctl"}, {tx_start, dut_clk, dut_se, dut_tm, busy, err}, 0);
    check({nm, "_txd"}, tx_data, 0);
    check({nm, "_pis"}, dut_pis, 0);
    check({nm, "_si"}, scan_in, 0);
    check({nm, "_cc"}, cycle_count, 0);
    check({nm, "_rstn"}, dut_rstn, 0);
  endtask

  typedef struct {
    int nb;
    logic [7:0] b0, b1, b2, rep;
    logic er;
    logic [15:0] cc;
    int rises, rlow;
    logic [13:0] pis;
  } vec_t;
  vec_t vt[10];

  initial begin
    int r0, h0, l0, t;
    logic [15:0] cc0;
    vt[0] = '{1, "r",   8'h00, 8'h00, "K", 1'b0, 16'd0, 0, 16, 14'h0000};
    vt[1] = '{3, "e",   8'h00, 8'h05, "K", 1'b0, 16'd5, 5, 0,  14'h0000};
    vt[2] = '{3, "e",   8'h00, 8'h00, "K", 1'b0, 16'd5, 0, 0,  14'h0000};
    vt[3] = '{1, 8'h7A, 8'h00, 8'h00, "E", 1'b1, 16'd5, 0, 0,  14'h0000};
    vt[4] = '{3, "e",   8'h00, 8'h03, "K", 1'b1, 16'd8, 3, 0,  14'h0000};
    vt[5] = '{1, "r",   8'h00, 8'h00, "K", 1'b0, 16'd0, 0, 16, 14'h0000};
    vt[6] = '{3, "i",   8'h2A, 8'h5C, "K", 1'b0, 16'd0, 0, 0,  14'h2A5C};
    vt[7] = '{3, "x",   8'h00, 8'h00, "K", 1'b0, 16'd0, 0, 0,  14'h2A5C};
    vt[8] = '{3, "i",   8'hFF, 8'hFF, "K", 1'b0, 16'd0, 0, 0,  14'h3FFF};
    vt[9] = '{3, "i",   8'h00, 8'h01, "K", 1'b0, 16'd0, 0, 0,  14'h0001};

    repeat (3) @(posedge clk);
    #1 check_reset("rst");
    rst = 1'b0;
    @(posedge clk);
    #1 check("rst_rstn_rel", dut_rstn, 1);

    for (int i = 0; i < 10; i++) begin
      r0 = mon_rise;
      h0 = mon_high;
      l0 = mon_rlow;
      send(vt[i].b0);
      if (vt[i].nb > 1) send(vt[i].b1);
      if (vt[i].nb > 2) send(vt[i].b2);
      expect_byte($sformatf("v%0d_reply", i), vt[i].rep);
      wait_idle($sformatf("v%0d_busy", i));
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_err", i), err, vt[i].er);
      check($sformatf("v%0d_cc", i), cycle_count, vt[i].cc);
      check($sformatf("v%0d_rises", i), mon_rise - r0, vt[i].rises);
      check($sformatf("v%0d_highs", i), mon_high - h0, vt[i].rises * CD);
      check($sformatf("v%0d_rlow", i), mon_rlow - l0, vt[i].rlow);
      check($sformatf("v%0d_pis", i), dut_pis, vt[i].pis);
    end

    // bytes arriving during the reset pulse are dropped
    send("r");
    send(8'h7A);
    expect_byte("ign_reply", "K");
    wait_idle("ign_busy");
    repeat (10) @(posedge clk);
    #1 check("ign_err", err, 0);
    check("ign_extra", txlog.size() - ri, 0);

    cc0 = cycle_count;
    for (int p = 0; p < 2; p++) begin
      send("x");
      send(8'h00);
      send(8'h03);
      for (int k = 0; k < 3; k++) begin
        send(p == 0 ? 8'(k + 1) : 8'h00);
        expect_byte($sformatf("x%0d_%0d", p, k), p == 0 ? 8'h00 : 8'(k + 1));
        if (k == 0) check($sformatf("x%0d_se_tm", p), {dut_se, dut_tm}, 3);
        repeat (8) @(posedge clk);
      end
      wait_idle($sformatf("x%0d_busy", p));
      repeat (10) @(posedge clk);
      #1 check($sformatf("x%0d_extra", p), txlog.size() - ri, 0);
      check($sformatf("x%0d_clk", p), dut_clk, 0);
    end
    check("x_cc_hold", cycle_count, cc0);

    dut_pos = 11'h5A5;
    send("o");
    expect_byte("o_b0", 8'h05);
    expect_byte("o_b1", 8'hA5);
    wait_idle("o_busy");
    repeat (10) @(posedge clk);
    #1 check("o_extra", txlog.size() - ri, 0);

    cc0 = cycle_count;
    r0 = mon_rise;
    h0 = mon_high;
    send("f");
    repeat (100) @(posedge clk);
    send("p");
    expect_byte("f_reply", "K");
    wait_idle("f_busy");
    repeat (2) @(posedge clk);
    #1 check("f_clk_low", dut_clk, 0);
    check("f_cc", cycle_count, 16'(cc0 + 16'(mon_rise - r0)));
    check("f_full_periods", mon_high - h0, (mon_rise - r0) * CD);
    check("f_ran", (mon_rise - r0) > 20, 1);
    check("f_se", dut_se, 0);

    send("e");
    send(8'h00);
    t = 0;
    while (txlog.size() <= ri && t < 200) begin
      @(posedge clk);
      #2 t++;
    end
    check("to_latency", t >= 41 && t <= 45, 1);
    expect_byte("to_reply", "T");
    wait_idle("to_busy");
    #1 check("to_err", err, 1);

    send("x");
    send(8'h00);
    send(8'h02);
    send(8'h03);
    repeat (2) @(posedge clk);
    #1 check("mid_pre", {dut_se, scan_in}, 3'b111);
    rst = 1'b1;
    @(posedge clk);
    #1 check_reset("mid");
    rst = 1'b0;
    @(posedge clk);
    #1 check("mid_rstn_rel", dut_rstn, 1);
    check("mid_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
